fwd_hazard_unit: RTL and testbench
==================================

# fwd_hazard_unit

Parametrised forwarding and load-use hazard unit for the EX stage of the MIPS pipeline. It selects, per EX source operand, the youngest later pipeline stage that writes that register. It also detects load-use hazards against the ID stage and stalls for as many cycles as a configurable load latency requires. It replaces the fixed two-source, two-stage forwarding logic and adds the stall state machine, flush handling, a sticky hazard-error flag and a stall counter.

## Interface
- `REG_AW`, 5: register address width.
- `N_SRC`, 2: source operands per instruction.
- `N_FWD`, 2: forwarding stages after EX. Index 0 is the youngest (MEM), index 1 is WB, and so on.
- `LOAD_LAT`, 1: load data is usable from stage index `LOAD_LAT` onward. Constraint: `1 ≤ LOAD_LAT ≤ N_FWD-1`.
- `SEL_W`, derived as `$clog2(N_FWD+1)`: forward-select width.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: asynchronous reset, active-high.
- `i_ex_src` in `N_SRC*REG_AW`: EX source registers; operand j is at slice j.
- `i_fwd_rd` in `N_FWD*REG_AW`: destination register of each forwarding stage.
- `i_fwd_reg_write` in `N_FWD`: per-stage register write enable.
- `i_fwd_is_load` in `N_FWD`: per-stage flag, instruction is a load.
- `i_ex_rd` in `REG_AW`, `i_ex_reg_write` in 1, `i_ex_is_load` in 1: the instruction currently in EX.
- `i_id_src` in `N_SRC*REG_AW`, `i_id_src_used` in `N_SRC`: ID source registers and their per-operand read flags.
- `i_flush` in 1: branch/jump flush of IF/ID.
- `o_forward` out `N_SRC*SEL_W`: per-operand select. 0 means register file; k means stage k-1.
- `o_stall` out 1: hold PC and IF/ID, and insert a bubble into ID/EX.
- `o_hazard_err` out 1: sticky error flag.
- `o_stall_count` out 16: saturating count of stall cycles.

## Operation
- **Stage match.** Stage k matches operand j when `fwd_reg_write[k]`, `fwd_rd[k] != 0` and `fwd_rd[k] == ex_src[j]`.
- **Forward select.** `o_forward[j]` is k+1 for the lowest matching k, otherwise 0. Register 0 is never forwarded.
- **Data readiness.** Stage k holds valid data unless `fwd_is_load[k]` and `k < LOAD_LAT`.
  - If the selected stage holds invalid data, `o_hazard_err` is set at the next edge.
  - The flag clears only on reset.
- **Load-use need, from EX.** A load in EX with `ex_reg_write` and `ex_rd != 0` matching any used ID source gives need = `LOAD_LAT`.
- **Load-use need, from a forwarding stage.** A load in stage k, with `k ≤ LOAD_LAT-2` and matching under the same conditions, gives need = `LOAD_LAT-1-k`.
- **Combined need.** The hazard need is the maximum over all sources; 0 means no hazard.
- **FSM states.** RUN and STALL, with a down-counter `cnt` of width `$clog2(N_FWD+1)`.
- **RUN.** When need > 0 and `!i_flush`:
  - `o_stall` = 1 in the same cycle;
  - `cnt` ← need-1, then go to STALL if need > 1, else stay in RUN.
- **STALL.**
  - `o_stall` = 1.
  - Hazard detection is ignored; the bubbles entering EX carry `reg_write` = 0.
  - If `cnt == 1`, go to RUN; otherwise `cnt` decrements.
- **Flush.**
  - `i_flush` in RUN suppresses a stall that same cycle.
  - `i_flush` in STALL forces RUN and drops `o_stall` in that cycle. The dependent instruction is squashed.
  - When flush and a hazard occur together, flush wins.
- **Stall counter.** `o_stall_count` increments on every edge where `o_stall` = 1 and saturates at 16'hFFFF.

## Timing
- `o_forward` is combinational from the inputs, with zero latency.
- `o_stall` is a Mealy output, valid in the detection cycle.
- A load-use with need N produces exactly N consecutive stall cycles, unless a flush cuts it short.
- Reset values:
  - state RUN, `cnt` 0;
  - `o_stall` 0;
  - `o_hazard_err` 0;
  - `o_stall_count` 0;
  - `o_forward` forced to 0 while `i_rst` is high.
- Reset asserted mid-STALL returns the unit to RUN immediately and asynchronously.

## Structure
- Shared package `fwd_pkg`:
  - select encoding constant `FWD_SEL_RF` = 0;
  - state encodings `ST_RUN` and `ST_STALL`;
  - `SEL_W` and the `cnt` width functions.
- One natural sub-module, `fwd_select`: a purely combinational per-operand priority match, instantiated `N_SRC` times via generate.
- The top level holds the need computation, the FSM, the error flag and the counter.

## Test plan
- **Default parameters, forwarding priority.** Set stage 0 rd = 3 (write), stage 1 rd = 3 (write), `ex_src0` = 3 → `o_forward[0]` = 1. Clear stage 0's write enable → `o_forward[0]` = 2.
- **Register 0.** Set `ex_src1` = 0 with stage 0 rd = 0 (write) → `o_forward[1]` = 0.
- **Load-use stall, `LOAD_LAT` = 1.** Put a load rd = 5 in EX and ID src0 = 5 (used) → `o_stall` = 1 for exactly 1 cycle. On the next cycle the load is in stage 1, and selecting it gives `o_forward` = 2 with `o_hazard_err` = 0.
- **`LOAD_LAT` = 2, `N_FWD` = 3.**
  - Load rd = 7 in EX, ID reads r7 → 2 stall cycles, `o_stall_count` = 2.
  - Load rd = 7 in stage 0, ID reads r7 → 1 stall cycle.
- **Flush.** With `LOAD_LAT` = 2 and the unit in its first STALL cycle (`cnt` = 1), assert `i_flush` → `o_stall` = 0 that cycle, state RUN, and `o_stall_count` = 1.
- **Error and reset.** Force stage 0 to be a load rd = 4 while `ex_src0` = 4 → `o_hazard_err` = 1 after the edge and held. Pulse `i_rst` → `o_hazard_err` = 0 and `o_stall_count` = 0.

Source files
------------

// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard unit.
package fwd_pkg;

    // Forward select value meaning "take the operand from the register file".
    localparam int unsigned FWD_SEL_RF = 0;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } fsm_state_e;

    // Select must encode 0 (register file) plus one code per forwarding stage.
    function automatic int unsigned sel_width(input int unsigned n_fwd);
        return $clog2(n_fwd + 1);
    endfunction

    // Stall down-counter must hold the largest need, which never exceeds n_fwd.
    function automatic int unsigned cnt_width(input int unsigned n_fwd);
        return $clog2(n_fwd + 1);
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand priority match: pick the youngest later stage writing the source register.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned N_FWD    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SEL_W    = sel_width(N_FWD)
) (
    input  logic [REG_AW-1:0]       src,
    input  logic [N_FWD*REG_AW-1:0] fwd_rd,
    input  logic [N_FWD-1:0]        fwd_reg_write,
    input  logic [N_FWD-1:0]        fwd_is_load,
    output logic [SEL_W-1:0]        sel,
    output logic                    data_bad
);

    // Scan oldest to youngest so the last hit (lowest index) wins; r0 never matches.
    always_comb begin
        sel      = SEL_W'(FWD_SEL_RF);
        data_bad = 1'b0;
        for (int k = int'(N_FWD) - 1; k >= 0; k--) begin
            if (fwd_reg_write[k] && (fwd_rd[k*REG_AW +: REG_AW] != '0) &&
                (fwd_rd[k*REG_AW +: REG_AW] == src)) begin
                sel      = SEL_W'(k + 1);
                // A load whose data is not yet back cannot be forwarded from here.
                data_bad = fwd_is_load[k] && (k < int'(LOAD_LAT));
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding selects plus load-use stall FSM, sticky error flag and stall counter.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned N_SRC    = 2,
    parameter int unsigned N_FWD    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned SEL_W    = sel_width(N_FWD)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_SRC*REG_AW-1:0] i_ex_src,
    input  logic [N_FWD*REG_AW-1:0] i_fwd_rd,
    input  logic [N_FWD-1:0]        i_fwd_reg_write,
    input  logic [N_FWD-1:0]        i_fwd_is_load,
    input  logic [REG_AW-1:0]       i_ex_rd,
    input  logic                    i_ex_reg_write,
    input  logic                    i_ex_is_load,
    input  logic [N_SRC*REG_AW-1:0] i_id_src,
    input  logic [N_SRC-1:0]        i_id_src_used,
    input  logic                    i_flush,
    output logic [N_SRC*SEL_W-1:0]  o_forward,
    output logic                    o_stall,
    output logic                    o_hazard_err,
    output logic [15:0]             o_stall_count
);

    localparam int unsigned CNT_W = cnt_width(N_FWD);

    logic [N_SRC*SEL_W-1:0] fwd_sel;
    logic [N_SRC-1:0]       fwd_bad;
    logic [CNT_W-1:0]       need;
    logic                   stall;
    fsm_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    for (genvar j = 0; j < N_SRC; j++) begin : g_src
        fwd_select #(
            .REG_AW   (REG_AW),
            .N_FWD    (N_FWD),
            .LOAD_LAT (LOAD_LAT),
            .SEL_W    (SEL_W)
        ) u_fwd_select (
            .src           (i_ex_src[j*REG_AW +: REG_AW]),
            .fwd_rd        (i_fwd_rd),
            .fwd_reg_write (i_fwd_reg_write),
            .fwd_is_load   (i_fwd_is_load),
            .sel           (fwd_sel[j*SEL_W +: SEL_W]),
            .data_bad      (fwd_bad[j])
        );
    end

    assign o_forward = i_rst ? '0 : fwd_sel;

    // Bubbles needed: a load in EX needs LOAD_LAT, one already in stage k needs LOAD_LAT-1-k.
    always_comb begin
        need = '0;
        for (int j = 0; j < int'(N_SRC); j++) begin
            if (i_id_src_used[j]) begin
                if (i_ex_is_load && i_ex_reg_write && (i_ex_rd != '0) &&
                    (i_ex_rd == i_id_src[j*REG_AW +: REG_AW])) begin
                    if (CNT_W'(LOAD_LAT) > need) need = CNT_W'(LOAD_LAT);
                end
                for (int k = 0; k <= int'(LOAD_LAT) - 2; k++) begin
                    if (i_fwd_is_load[k] && i_fwd_reg_write[k] &&
                        (i_fwd_rd[k*REG_AW +: REG_AW] != '0) &&
                        (i_fwd_rd[k*REG_AW +: REG_AW] == i_id_src[j*REG_AW +: REG_AW])) begin
                        if (CNT_W'(int'(LOAD_LAT) - 1 - k) > need) begin
                            need = CNT_W'(int'(LOAD_LAT) - 1 - k);
                        end
                    end
                end
            end
        end
    end

    // Next-state and Mealy stall: first stall cycle comes from RUN, the rest are counted in STALL.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if ((need != '0) && !i_flush) begin
                    stall   = 1'b1;
                    cnt_d   = need - CNT_W'(1);
                    state_d = (need > CNT_W'(1)) ? ST_STALL : ST_RUN;
                end
            end
            ST_STALL: begin
                if (i_flush) begin
                    // Dependent instruction is squashed, so the remaining bubbles are moot.
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    stall = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_stall = stall && !i_rst;

    // FSM state and stall down-counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Sticky flag: an operand was forwarded from a stage whose load data is not back yet.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_hazard_err <= 1'b0;
        end else if (|fwd_bad) begin
            o_hazard_err <= 1'b1;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_stall_count <= '0;
        end else if (o_stall && (o_stall_count != 16'hFFFF)) begin
            o_stall_count <= o_stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench: directed steps on a default and a LOAD_LAT=2/N_FWD=3 instance, then random vs a model.
module tb_fwd_hazard_unit;

    localparam int AW    = 5;
    localparam int B_NF  = 3;
    localparam int B_LAT = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // Instance A: default parameters
    logic [2*AW-1:0] a_ex_src, a_id_src, a_fwd_rd;
    logic [1:0]      a_fwd_we, a_fwd_ld, a_id_used;
    logic [AW-1:0]   a_ex_rd;
    logic            a_ex_we, a_ex_ld, a_flush;
    logic [3:0]      a_forward;
    logic            a_stall, a_err;
    logic [15:0]     a_cnt;

    // Instance B: N_FWD=3, LOAD_LAT=2
    logic [2*AW-1:0]    b_ex_src, b_id_src;
    logic [B_NF*AW-1:0] b_fwd_rd;
    logic [B_NF-1:0]    b_fwd_we, b_fwd_ld;
    logic [1:0]         b_id_used;
    logic [AW-1:0]      b_ex_rd;
    logic               b_ex_we, b_ex_ld, b_flush;
    logic [3:0]         b_forward;
    logic               b_stall, b_err;
    logic [15:0]        b_cnt;

    fwd_hazard_unit u_dut_a (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_ex_src        (a_ex_src),
        .i_fwd_rd        (a_fwd_rd),
        .i_fwd_reg_write (a_fwd_we),
        .i_fwd_is_load   (a_fwd_ld),
        .i_ex_rd         (a_ex_rd),
        .i_ex_reg_write  (a_ex_we),
        .i_ex_is_load    (a_ex_ld),
        .i_id_src        (a_id_src),
        .i_id_src_used   (a_id_used),
        .i_flush         (a_flush),
        .o_forward       (a_forward),
        .o_stall         (a_stall),
        .o_hazard_err    (a_err),
        .o_stall_count   (a_cnt)
    );

    fwd_hazard_unit #(
        .N_FWD    (B_NF),
        .LOAD_LAT (B_LAT)
    ) u_dut_b (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_ex_src        (b_ex_src),
        .i_fwd_rd        (b_fwd_rd),
        .i_fwd_reg_write (b_fwd_we),
        .i_fwd_is_load   (b_fwd_ld),
        .i_ex_rd         (b_ex_rd),
        .i_ex_reg_write  (b_ex_we),
        .i_ex_is_load    (b_ex_ld),
        .i_id_src        (b_id_src),
        .i_id_src_used   (b_id_used),
        .i_flush         (b_flush),
        .o_forward       (b_forward),
        .o_stall         (b_stall),
        .o_hazard_err    (b_err),
        .o_stall_count   (b_cnt)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_pulse();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic a_idle();
        a_ex_src = '0; a_id_src = '0; a_fwd_rd = '0; a_fwd_we = '0; a_fwd_ld = '0;
        a_id_used = '0; a_ex_rd = '0; a_ex_we = 1'b0; a_ex_ld = 1'b0; a_flush = 1'b0;
    endtask

    task automatic b_idle();
        b_ex_src = '0; b_id_src = '0; b_fwd_rd = '0; b_fwd_we = '0; b_fwd_ld = '0;
        b_id_used = '0; b_ex_rd = '0; b_ex_we = 1'b0; b_ex_ld = 1'b0; b_flush = 1'b0;
    endtask

    // Reference for instance B: youngest stage writing a nonzero register equal to the source.
    function automatic int m_sel(input int j);
        logic [AW-1:0] s, rd;
        s = b_ex_src[j*AW +: AW];
        for (int k = 0; k < B_NF; k++) begin
            rd = b_fwd_rd[k*AW +: AW];
            if (b_fwd_we[k] && rd != 0 && rd == s) return k + 1;
        end
        return 0;
    endfunction

    // Load data exists only once the load has reached stage LOAD_LAT.
    function automatic bit m_bad(input int j);
        int sel;
        sel = m_sel(j);
        return (sel != 0) && b_fwd_ld[sel-1] && (sel - 1 < B_LAT);
    endfunction

    // A load d stages past EX (EX itself is d=0) still owes LOAD_LAT-d cycles to the reader in ID.
    function automatic int m_need();
        int n;
        logic [AW-1:0] s, rd;
        n = 0;
        for (int j = 0; j < 2; j++) begin
            if (b_id_used[j]) begin
                s = b_id_src[j*AW +: AW];
                if (b_ex_we && b_ex_ld && b_ex_rd != 0 && b_ex_rd == s && B_LAT > n) n = B_LAT;
                for (int k = 0; k < B_NF; k++) begin
                    rd = b_fwd_rd[k*AW +: AW];
                    if (b_fwd_we[k] && b_fwd_ld[k] && rd != 0 && rd == s && B_LAT - (k + 1) > n)
                        n = B_LAT - (k + 1);
                end
            end
        end
        return n;
    endfunction

    int m_left, m_cnt, m_need_v;
    bit m_err, e_stall, e_bad;

    initial begin
        rst = 1'b1;
        a_idle();
        b_idle();
        // Forwarding is masked while reset is held
        a_fwd_rd[AW-1:0] = 5'd3; a_fwd_we[0] = 1'b1; a_ex_src[AW-1:0] = 5'd3;
        #3;
        chk("rst_fwd_masked", 32'(a_forward), 0);
        chk("rst_stall", 32'(a_stall), 0);
        chk("rst_err", 32'(a_err), 0);
        chk("rst_cnt", 32'(a_cnt), 0);
        chk("rst_b_cnt", 32'(b_cnt), 0);
        tick();
        tick();
        #2 rst = 1'b0;
        tick();

        // ---- Instance A: forwarding priority ----
        a_fwd_rd = {5'd3, 5'd3}; a_fwd_we = 2'b11; a_ex_src = {5'd9, 5'd3};
        #2;
        chk("a_prio_young", 32'(a_forward[1:0]), 1);
        a_fwd_we = 2'b10;
        #1;
        chk("a_prio_old", 32'(a_forward[1:0]), 2);
        chk("a_src1_nomatch", 32'(a_forward[3:2]), 0);
        // Register 0 is never forwarded
        a_fwd_rd = {5'd3, 5'd0}; a_fwd_we = 2'b11; a_ex_src = {5'd0, 5'd3};
        #1;
        chk("a_r0_never", 32'(a_forward[3:2]), 0);
        chk("a_r0_src0_stage1", 32'(a_forward[1:0]), 2);
        tick();
        chk("a_no_err", 32'(a_err), 0);

        // ---- Instance A: load-use, LOAD_LAT=1 ----
        a_idle();
        a_ex_rd = 5'd5; a_ex_we = 1'b1; a_ex_ld = 1'b1; a_id_src = {5'd0, 5'd5};
        a_id_used = 2'b01;
        #2;
        chk("a_lu_stall", 32'(a_stall), 1);
        tick();
        chk("a_lu_cnt", 32'(a_cnt), 1);
        a_ex_rd = '0; a_ex_we = 1'b0; a_ex_ld = 1'b0;
        a_fwd_rd = {5'd5, 5'd0}; a_fwd_we = 2'b10; a_fwd_ld = 2'b10; a_ex_src = {5'd0, 5'd5};
        #2;
        chk("a_lu_one_cycle", 32'(a_stall), 0);
        chk("a_lu_fwd", 32'(a_forward[1:0]), 2);
        tick();
        chk("a_lu_no_err", 32'(a_err), 0);
        chk("a_lu_cnt_hold", 32'(a_cnt), 1);
        a_idle();

        // ---- Instance B: load in EX needs two stalls ----
        b_ex_rd = 5'd7; b_ex_we = 1'b1; b_ex_ld = 1'b1; b_id_src = {5'd0, 5'd7};
        b_id_used = 2'b01;
        #2;
        chk("b_ex2_stall0", 32'(b_stall), 1);
        tick();
        b_ex_rd = '0; b_ex_we = 1'b0; b_ex_ld = 1'b0;
        b_fwd_rd = {5'd0, 5'd0, 5'd7}; b_fwd_we = 3'b001; b_fwd_ld = 3'b001;
        #2;
        chk("b_ex2_stall1", 32'(b_stall), 1);
        tick();
        b_fwd_rd = {5'd0, 5'd7, 5'd0}; b_fwd_we = 3'b010; b_fwd_ld = 3'b010;
        #2;
        chk("b_ex2_done", 32'(b_stall), 0);
        tick();
        chk("b_ex2_cnt", 32'(b_cnt), 2);

        // ---- Instance B: load in stage 0 needs one stall ----
        b_idle();
        b_fwd_rd = {5'd0, 5'd0, 5'd7}; b_fwd_we = 3'b001; b_fwd_ld = 3'b001;
        b_id_src = {5'd0, 5'd7}; b_id_used = 2'b01;
        #2;
        chk("b_s0_stall", 32'(b_stall), 1);
        tick();
        b_fwd_rd = {5'd0, 5'd7, 5'd0}; b_fwd_we = 3'b010; b_fwd_ld = 3'b010;
        #2;
        chk("b_s0_one", 32'(b_stall), 0);
        tick();
        chk("b_s0_cnt", 32'(b_cnt), 3);

        // ---- Instance B: flush in the first STALL cycle ----
        b_idle();
        rst_pulse();
        chk("b_flush_cnt0", 32'(b_cnt), 0);
        b_ex_rd = 5'd7; b_ex_we = 1'b1; b_ex_ld = 1'b1; b_id_src = {5'd0, 5'd7};
        b_id_used = 2'b01;
        #2;
        chk("b_flush_first", 32'(b_stall), 1);
        tick();
        b_ex_rd = '0; b_ex_we = 1'b0; b_ex_ld = 1'b0; b_flush = 1'b1;
        #2;
        chk("b_flush_stall", 32'(b_stall), 0);
        tick();
        chk("b_flush_cnt", 32'(b_cnt), 1);
        b_idle();
        #2;
        chk("b_flush_run", 32'(b_stall), 0);
        tick();

        // ---- Instance B: sticky hazard error ----
        b_fwd_rd = {5'd0, 5'd0, 5'd4}; b_fwd_we = 3'b001; b_fwd_ld = 3'b001;
        b_ex_src = {5'd0, 5'd4};
        #2;
        chk("b_err_fwd", 32'(b_forward[1:0]), 1);
        chk("b_err_pre", 32'(b_err), 0);
        tick();
        chk("b_err_set", 32'(b_err), 1);
        b_idle();
        tick();
        chk("b_err_sticky", 32'(b_err), 1);
        rst_pulse();
        chk("b_err_rst", 32'(b_err), 0);
        chk("b_cnt_rst", 32'(b_cnt), 0);

        // ---- Instance B: asynchronous reset in the middle of a stall ----
        b_ex_rd = 5'd7; b_ex_we = 1'b1; b_ex_ld = 1'b1; b_id_src = {5'd0, 5'd7};
        b_id_used = 2'b01;
        tick();
        b_ex_rd = '0; b_ex_we = 1'b0; b_ex_ld = 1'b0;
        #2;
        chk("b_mid_stall", 32'(b_stall), 1);
        rst = 1'b1;
        #1;
        chk("b_async_stall", 32'(b_stall), 0);
        chk("b_async_cnt", 32'(b_cnt), 0);
        rst = 1'b0;
        #1;
        chk("b_after_rst_run", 32'(b_stall), 0);
        tick();
        chk("b_after_rst_cnt", 32'(b_cnt), 0);

        // ---- Instance B: random traffic against the reference model ----
        b_idle();
        rst_pulse();
        m_left = 0; m_cnt = 0; m_err = 1'b0;
        for (int it = 0; it < 400; it++) begin
            if (it % 50 == 49) begin
                b_idle();
                rst_pulse();
                m_left = 0; m_cnt = 0; m_err = 1'b0;
            end
            for (int j = 0; j < 2; j++) begin
                b_ex_src[j*AW +: AW] = 5'($urandom_range(0, 3));
                b_id_src[j*AW +: AW] = 5'($urandom_range(0, 3));
            end
            for (int k = 0; k < B_NF; k++) b_fwd_rd[k*AW +: AW] = 5'($urandom_range(0, 3));
            b_fwd_we  = 3'($urandom);
            b_fwd_ld  = 3'($urandom);
            b_id_used = 2'($urandom);
            b_ex_rd   = 5'($urandom_range(0, 3));
            b_ex_we   = 1'($urandom);
            b_ex_ld   = 1'($urandom);
            b_flush   = ($urandom_range(0, 5) == 0);
            #2;
            m_need_v = m_need();
            e_stall  = (m_left > 0) ? !b_flush : ((m_need_v > 0) && !b_flush);
            e_bad    = m_bad(0) || m_bad(1);
            chk("rnd_fwd0", 32'(b_forward[1:0]), m_sel(0));
            chk("rnd_fwd1", 32'(b_forward[3:2]), m_sel(1));
            chk("rnd_stall", 32'(b_stall), 32'(e_stall));
            tick();
            if (m_left > 0) m_left = b_flush ? 0 : m_left - 1;
            else if (e_stall) m_left = m_need_v - 1;
            if (e_stall && m_cnt < 65535) m_cnt++;
            if (e_bad) m_err = 1'b1;
            chk("rnd_err", 32'(b_err), 32'(m_err));
            chk("rnd_cnt", 32'(b_cnt), m_cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
